// File: rtl/video_mode_sequencer_if.sv
// Control and timing bundle of the test-pattern video sequencer.
// master drives mode/phase controls, slave returns timing/phase/mute.
interface video_mode_sequencer_if #(
    parameter int PHASE_W = 10
);
    logic               pal_in;
    logic               scandouble_in;
    logic [PHASE_W-1:0] phase_step;
    logic               pause;
    logic               ce_pix;
    logic [9:0]         hc;
    logic [9:0]         vc;
    logic               hblank;
    logic               hsync;
    logic               vblank;
    logic               vsync;
    logic               pal;
    logic               scandouble;
    logic [PHASE_W-1:0] phase;
    logic               mute;
    logic               frame_start;
    logic [15:0]        frame_cnt;

    modport master (
        output pal_in, scandouble_in, phase_step, pause,
        input  ce_pix, hc, vc, hblank, hsync, vblank, vsync,
        input  pal, scandouble, phase, mute, frame_start, frame_cnt
    );

    modport slave (
        input  pal_in, scandouble_in, phase_step, pause,
        output ce_pix, hc, vc, hblank, hsync, vblank, vsync,
        output pal, scandouble, phase, mute, frame_start, frame_cnt
    );
endinterface

// File: rtl/video_mode_sequencer.sv
// Timing/sequencing controller for the test-pattern video path.
// Optional frame counter enabled by defining FRAME_CNT_EN.
module video_mode_sequencer #(
    parameter int H_LAST        = 637,
    parameter int H_BLANK_START = 529,
    parameter int H_SYNC_START  = 544,
    parameter int H_SYNC_END    = 590,
    parameter int MUTE_FRAMES   = 2,
    parameter int PHASE_W       = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    video_mode_sequencer_if.slave  vif
);
    localparam logic [9:0] HL  = 10'(H_LAST);
    localparam logic [9:0] HBS = 10'(H_BLANK_START);
    localparam logic [9:0] HSS = 10'(H_SYNC_START);
    localparam logic [9:0] HSE = 10'(H_SYNC_END);
    localparam logic [3:0] MUTE_INIT = 4'(MUTE_FRAMES - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_PENDING,
        S_MUTE
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         sync1_q, sync2_q;
    logic               pal_q, pal_d;
    logic               sd_q, sd_d;
    logic               ce_q;
    logic [9:0]         hc_q, hc_d;
    logic [9:0]         vc_q, vc_d;
    logic               hblank_q, hsync_q, vblank_q, vsync_q;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [3:0]         mcnt_q, mcnt_d;
    logic               load;
    logic               eof;
    logic               adv;
    logic               mode_diff;
    logic [9:0]         v_last, vb_start, vs_start, vs_end;

    // Per-mode vertical geometry
    always_comb begin
        v_last   = 10'd261;
        vb_start = 10'd240;
        vs_start = 10'd245;
        vs_end   = 10'd248;
        case ({pal_q, sd_q})
            2'b01: begin
                v_last   = 10'd523;
                vb_start = 10'd480;
                vs_start = 10'd490;
                vs_end   = 10'd496;
            end
            2'b10: begin
                v_last   = 10'd311;
                vb_start = 10'd300;
                vs_start = 10'd304;
                vs_end   = 10'd308;
            end
            2'b11: begin
                v_last   = 10'd623;
                vb_start = 10'd600;
                vs_start = 10'd608;
                vs_end   = 10'd616;
            end
            default: ;
        endcase
    end

    assign eof       = ce_q & (hc_q == HL) & (vc_q == v_last);
    assign adv       = eof & ~vif.pause;
    assign mode_diff = (sync2_q != {pal_q, sd_q});

    // Two-flop synchronizer for the asynchronous mode pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {vif.pal_in, vif.scandouble_in};
            sync2_q <= sync1_q;
        end
    end

    // Mode FSM: defer switches to a frame edge, then mute
    always_comb begin
        state_d = state_q;
        pal_d   = pal_q;
        sd_d    = sd_q;
        phase_d = phase_q;
        mcnt_d  = mcnt_q;
        load    = 1'b0;
        case (state_q)
            S_RUN: begin
                if (adv) phase_d = phase_q + vif.phase_step;
                if (mode_diff) state_d = S_PENDING;
            end
            S_PENDING: begin
                if (adv) phase_d = phase_q + vif.phase_step;
                if (!mode_diff) begin
                    state_d = S_RUN;
                end else if (eof) begin
                    load    = 1'b1;
                    state_d = S_MUTE;
                end
            end
            S_MUTE: begin
                if (eof) begin
                    if (mode_diff) load = 1'b1;
                    else if (mcnt_q == 4'd0) state_d = S_RUN;
                    else mcnt_d = mcnt_q - 4'd1;
                end
            end
            default: state_d = S_MUTE;
        endcase
        if (load) begin
            {pal_d, sd_d} = sync2_q;
            phase_d       = '0;
            mcnt_d        = MUTE_INIT;
        end
    end

    // Pixel counters, advancing on pixel enables only
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (ce_q) begin
            if (hc_q == HL) begin
                hc_d = '0;
                vc_d = (vc_q == v_last) ? 10'd0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
        if (load) begin
            hc_d = '0;
            vc_d = '0;
        end
    end

    // State, mode, counters and phase registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_MUTE;
            pal_q   <= 1'b0;
            sd_q    <= 1'b0;
            ce_q    <= 1'b0;
            hc_q    <= '0;
            vc_q    <= '0;
            phase_q <= '0;
            mcnt_q  <= MUTE_INIT;
        end else begin
            state_q <= state_d;
            pal_q   <= pal_d;
            sd_q    <= sd_d;
            ce_q    <= sd_q ? 1'b1 : ~ce_q;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            phase_q <= phase_d;
            mcnt_q  <= mcnt_d;
        end
    end

    // Blank/sync flags registered from the current counts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hblank_q <= 1'b0;
            hsync_q  <= 1'b0;
            vblank_q <= 1'b0;
            vsync_q  <= 1'b0;
        end else begin
            if (hc_q == HBS) hblank_q <= 1'b1;
            else if (hc_q == 10'd0) hblank_q <= 1'b0;
            if (hc_q == HSS) hsync_q <= 1'b1;
            else if (hc_q == HSE) hsync_q <= 1'b0;
            if (hc_q == HSS) begin
                if (vc_q == vb_start) vblank_q <= 1'b1;
                else if (vc_q == 10'd0) vblank_q <= 1'b0;
                if (vc_q == vs_start) vsync_q <= 1'b1;
                else if (vc_q == vs_end) vsync_q <= 1'b0;
            end
        end
    end

`ifdef FRAME_CNT_EN
    logic [15:0] fcnt_q;

    // Frames since the last mode load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) fcnt_q <= '0;
        else if (load) fcnt_q <= '0;
        else if (eof) fcnt_q <= fcnt_q + 16'd1;
    end

    assign vif.frame_cnt = fcnt_q;
`else
    assign vif.frame_cnt = '0;
`endif

    assign vif.ce_pix      = ce_q;
    assign vif.hc          = hc_q;
    assign vif.vc          = vc_q;
    assign vif.hblank      = hblank_q;
    assign vif.hsync       = hsync_q;
    assign vif.vblank      = vblank_q;
    assign vif.vsync       = vsync_q;
    assign vif.pal         = pal_q;
    assign vif.scandouble  = sd_q;
    assign vif.phase       = phase_q;
    assign vif.mute        = (state_q == S_MUTE);
    assign vif.frame_start = eof;
endmodule

// File: tb/tb_video_mode_sequencer.sv
// Bench for video_mode_sequencer: directed mode scenarios plus random
// pin/pause activity, checked every clock against a frame-level model.
module tb_video_mode_sequencer;
    localparam int HL  = 6;
    localparam int HBS = 3;
    localparam int HSS = 4;
    localparam int HSE = 5;
    localparam int MF  = 2;
    localparam int PW  = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;

    video_mode_sequencer_if #(.PHASE_W(PW)) ifc ();

    video_mode_sequencer #(
        .H_LAST       (HL - 1),
        .H_BLANK_START(HBS),
        .H_SYNC_START (HSS),
        .H_SYNC_END   (HSE),
        .MUTE_FRAMES  (MF),
        .PHASE_W      (PW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .vif  (ifc)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;

    int m_pos = 0, m_ce = 0, m_pal = 0, m_sd = 0;
    int m_s1 = 0, m_s2 = 0, m_prevmis = 0, m_left = MF;
    int m_phase = 0, m_fcnt = 0, m_seen = 0;
    int m_hb = 0, m_hs = 0, m_vb = 0, m_vs = 0;

    function automatic int lines(input int pal, input int sd);
        return (pal != 0 ? 312 : 262) * (sd != 0 ? 2 : 1);
    endfunction

    function automatic int vline(input int pal, input int sd,
                                 input int ntsc, input int p);
        return (pal != 0 ? p : ntsc) * (sd != 0 ? 2 : 1);
    endfunction

    function automatic int past(input int v, input int h, input int t);
        return (v > t || (v == t && h >= HSS)) ? 1 : 0;
    endfunction

    task automatic report();
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_all();
        int len;
        len = HL * lines(m_pal, m_sd);
        chk("ce_pix", 32'(ifc.ce_pix), m_ce);
        chk("hc", 32'(ifc.hc), m_pos % HL);
        chk("vc", 32'(ifc.vc), m_pos / HL);
        chk("hblank", 32'(ifc.hblank), m_hb);
        chk("hsync", 32'(ifc.hsync), m_hs);
        chk("vblank", 32'(ifc.vblank), m_vb);
        chk("vsync", 32'(ifc.vsync), m_vs);
        chk("pal", 32'(ifc.pal), m_pal);
        chk("scandouble", 32'(ifc.scandouble), m_sd);
        chk("phase", 32'(ifc.phase), m_phase);
        chk("mute", 32'(ifc.mute), (m_left > 0) ? 1 : 0);
        chk("frame_start", 32'(ifc.frame_start),
            (m_ce != 0 && m_pos == len - 1) ? 1 : 0);
`ifdef FRAME_CNT_EN
        chk("frame_cnt", 32'(ifc.frame_cnt), m_fcnt);
`else
        chk("frame_cnt", 32'(ifc.frame_cnt), 0);
`endif
    endtask

    // Model advance for one rising edge, using the inputs now applied
    task automatic mdl_step();
        int hc, vc, len, nce, mis;
        bit eof;
        len = HL * lines(m_pal, m_sd);
        hc  = m_pos % HL;
        vc  = m_pos / HL;
        eof = (m_ce != 0) && (m_pos == len - 1);
        mis = (m_s2 != m_pal * 2 + m_sd) ? 1 : 0;
        m_hb = (hc >= HBS) ? 1 : 0;
        m_hs = (hc >= HSS && hc < HSE) ? 1 : 0;
        if (vc == 0) m_vb = (hc < HSS) ? m_seen : 0;
        else m_vb = past(vc, hc, vline(m_pal, m_sd, 240, 300));
        m_vs = past(vc, hc, vline(m_pal, m_sd, 245, 304)) &
               (1 - past(vc, hc, vline(m_pal, m_sd, 248, 308)));
        nce = (m_sd != 0) ? 1 : 1 - m_ce;
        if (m_ce != 0) m_pos = eof ? 0 : m_pos + 1;
        if (eof) begin
            m_seen = 1;
            if (mis != 0 && (m_left > 0 || m_prevmis != 0)) begin
                m_pal   = m_s2 / 2;
                m_sd    = m_s2 % 2;
                m_left  = MF;
                m_phase = 0;
                m_fcnt  = 0;
            end else begin
                m_fcnt = (m_fcnt + 1) % 65536;
                if (m_left > 0) m_left--;
                else if (!ifc.pause)
                    m_phase = (m_phase + int'(ifc.phase_step)) % (1 << PW);
            end
        end
        m_ce      = nce;
        m_prevmis = mis;
        m_s2      = m_s1;
        m_s1      = int'(ifc.pal_in) * 2 + int'(ifc.scandouble_in);
    endtask

    task automatic tick();
        mdl_step();
        @(negedge clk);
        cyc++;
        chk_all();
        if (nfail >= 20) begin
            report();
            $finish;
        end
    endtask

    task automatic run_to_eof();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12000 && !seen; i++) begin
            tick();
            if (ifc.frame_start) seen = 1'b1;
        end
        chk("eof_wait", 32'(seen), 1);
        tick();
    endtask

    task automatic wait_vc(input int v);
        for (int i = 0; i < 12000 && int'(ifc.vc) != v; i++) tick();
        chk("vc_wait", 32'(ifc.vc), v);
    endtask

    initial begin
        int step, p0, f0, pulse;
        ifc.pal_in        = 1'b0;
        ifc.scandouble_in = 1'b0;
        ifc.phase_step    = 10'd6;
        ifc.pause         = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_all();
        reset = 1'b0;

        run_to_eof();
        chk("mute_f1", 32'(ifc.mute), 1);
        run_to_eof();
        chk("mute_exit", 32'(ifc.mute), 0);
        chk("phase_f2", 32'(ifc.phase), 0);
        run_to_eof();
        chk("phase_6", 32'(ifc.phase), 6);
        run_to_eof();
        chk("phase_12", 32'(ifc.phase), 12);
        run_to_eof();
        chk("phase_18", 32'(ifc.phase), 18);

        step = $urandom_range(1, 1023);
        ifc.phase_step = PW'(step);
        wait_vc(100);
        ifc.pal_in = 1'b1;
        run_to_eof();
        chk("sw_pal", 32'(ifc.pal), 1);
        chk("sw_phase", 32'(ifc.phase), 0);
        chk("sw_mute", 32'(ifc.mute), 1);
        run_to_eof();
        run_to_eof();
        chk("pal_unmute", 32'(ifc.mute), 0);
        run_to_eof();
        chk("pal_phase", 32'(ifc.phase), step);

        wait_vc(50);
        ifc.scandouble_in = 1'b1;
        repeat (5) tick();
        ifc.scandouble_in = 1'b0;
        repeat (6) tick();
        chk("glitch_mute", 32'(ifc.mute), 0);
        chk("glitch_sd", 32'(ifc.scandouble), 0);
        chk("glitch_phase", 32'(ifc.phase), step);

        ifc.pal_in = 1'b0;
        run_to_eof();
        chk("ntsc_pal", 32'(ifc.pal), 0);
        chk("ntsc_mute", 32'(ifc.mute), 1);
        wait_vc(30);
        ifc.pal_in = 1'b1;
        run_to_eof();
        chk("remute_pal", 32'(ifc.pal), 1);
        chk("remute_mute", 32'(ifc.mute), 1);
        run_to_eof();
        chk("remute_f1", 32'(ifc.mute), 1);
        run_to_eof();
        chk("remute_exit", 32'(ifc.mute), 0);

        ifc.phase_step = 10'd1023;
        ifc.pause      = 1'b1;
        p0 = m_phase;
        f0 = m_fcnt;
        repeat (3) run_to_eof();
        chk("pause_hold", 32'(ifc.phase), p0);
`ifdef FRAME_CNT_EN
        chk("pause_fcnt", 32'(ifc.frame_cnt), f0 + 3);
`endif
        ifc.pause = 1'b0;
        run_to_eof();
        chk("pause_rel", 32'(ifc.phase), (p0 + 1023) % 1024);

        pulse = 0;
        while (cyc < 80000) begin
            if ($urandom_range(0, 7999) == 0) begin
                ifc.pal_in        = 1'($urandom_range(0, 1));
                ifc.scandouble_in = 1'($urandom_range(0, 1));
            end
            if (pulse == 0 && $urandom_range(0, 2999) == 0) begin
                pulse = $urandom_range(1, 5);
                ifc.scandouble_in = ~ifc.scandouble_in;
            end else if (pulse > 0) begin
                pulse--;
                if (pulse == 0) ifc.scandouble_in = ~ifc.scandouble_in;
            end
            if ($urandom_range(0, 1999) == 0) ifc.pause = ~ifc.pause;
            if ($urandom_range(0, 4999) == 0)
                ifc.phase_step = PW'($urandom_range(0, 1023));
            tick();
        end

        report();
        $finish;
    end
endmodule
